// File: rtl/ym3438_mix_accum_if.sv
// Slot/frame bus of the YM3438 mix accumulator: per-slot MOL/MOR samples in,
// registered frame sums and status out.
interface ym3438_mix_accum_if #(
    parameter int OUT_W = 16
) ();
    logic             sample_en;
    logic             frame_start;
    logic [8:0]       MOL;
    logic [8:0]       MOR;
    logic [OUT_W-1:0] out_l;
    logic [OUT_W-1:0] out_r;
    logic             out_valid;
    logic             sync_err;
    logic             locked;

    modport master (
        output sample_en, frame_start, MOL, MOR,
        input  out_l, out_r, out_valid, sync_err, locked
    );

    modport slave (
        input  sample_en, frame_start, MOL, MOR,
        output out_l, out_r, out_valid, sync_err, locked
    );
endinterface

// File: rtl/ym3438_mix_accum.sv
// YM3438 output mixer: sums SLOTS offset-binary MOL/MOR slot values per frame
// into signed left/right samples. Locks on the first frame_start, free-runs on
// the slot count afterwards and resynchronises on an early frame_start.
module ym3438_mix_accum #(
    parameter int SLOTS = 24,
    parameter int OUT_W = 16
) (
    input  logic                MCLK,
    input  logic                reset,
    ym3438_mix_accum_if.slave   bus
);
    localparam int CNT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

    // Offset binary to signed: flipping the MSB subtracts 256.
    function automatic logic signed [8:0] to_signed9(input logic [8:0] v);
        return {~v[8], v[7:0]};
    endfunction

    // Sign-extend a converted slot value to accumulator width.
    function automatic logic signed [14:0] sext15(input logic signed [8:0] v);
        return {{6{v[8]}}, v};
    endfunction

    logic signed [14:0]  acc_l_r;
    logic signed [14:0]  acc_r_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                locked_r;
    logic [OUT_W-1:0]    out_l_r;
    logic [OUT_W-1:0]    out_r_r;
    logic                out_valid_r;
    logic                sync_err_r;

    logic signed [14:0]  slot_l_s;
    logic signed [14:0]  slot_r_s;
    logic signed [14:0]  sum_l_s;
    logic signed [14:0]  sum_r_s;
    logic                early_sync_s;

    // Slot conversion, running sums and early-frame_start detection.
    always_comb begin
        slot_l_s     = sext15(to_signed9(bus.MOL));
        slot_r_s     = sext15(to_signed9(bus.MOR));
        sum_l_s      = acc_l_r + slot_l_s;
        sum_r_s      = acc_r_r + slot_r_s;
        early_sync_s = 1'b0;
        if (bus.frame_start && (cnt_r != {CNT_W{1'b0}})) begin
            early_sync_s = 1'b1;
        end else begin
            early_sync_s = 1'b0;
        end
    end

    // Frame accumulation, lock tracking and registered frame outputs.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            acc_l_r     <= 15'sd0;
            acc_r_r     <= 15'sd0;
            cnt_r       <= {CNT_W{1'b0}};
            locked_r    <= 1'b0;
            out_l_r     <= {OUT_W{1'b0}};
            out_r_r     <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            if (bus.sample_en) begin
                if (!locked_r) begin
                    if (bus.frame_start) begin
                        // First frame_start: this slot becomes slot 0.
                        acc_l_r  <= slot_l_s;
                        acc_r_r  <= slot_r_s;
                        cnt_r    <= CNT_W'(1);
                        locked_r <= 1'b1;
                    end else begin
                        // Not yet locked: slot carries no frame position.
                        cnt_r <= cnt_r;
                    end
                end else if (early_sync_s) begin
                    // Early frame_start: drop the partial frame, restart here.
                    acc_l_r    <= slot_l_s;
                    acc_r_r    <= slot_r_s;
                    cnt_r      <= CNT_W'(1);
                    sync_err_r <= 1'b1;
                end else if (cnt_r == LAST_SLOT) begin
                    // Final slot: publish the full frame and start afresh.
                    out_l_r     <= OUT_W'(sum_l_s);
                    out_r_r     <= OUT_W'(sum_r_s);
                    out_valid_r <= 1'b1;
                    acc_l_r     <= 15'sd0;
                    acc_r_r     <= 15'sd0;
                    cnt_r       <= {CNT_W{1'b0}};
                end else begin
                    acc_l_r <= sum_l_s;
                    acc_r_r <= sum_r_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.out_l     = out_l_r;
    assign bus.out_r     = out_r_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sync_err  = sync_err_r;
    assign bus.locked    = locked_r;
endmodule

// File: tb/tb_ym3438_mix_accum.sv
// Scoreboard bench for ym3438_mix_accum: a list-of-slots frame model predicts
// every frame sum; a negedge monitor pops and compares on each out_valid.
module tb_ym3438_mix_accum;
    localparam int SLOTS = 24;
    localparam int OUT_W = 16;

    logic MCLK  = 1'b0;
    logic reset = 1'b1;

    ym3438_mix_accum_if #(.OUT_W(OUT_W)) bus ();

    ym3438_mix_accum #(.SLOTS(SLOTS), .OUT_W(OUT_W)) dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    int exp_l_q[$];
    int exp_r_q[$];
    int frame_l[$];
    int frame_r[$];
    bit m_locked   = 1'b0;
    int exp_sync   = 0;
    int seen_sync  = 0;
    int seen_valid = 0;
    int last_l     = 0;
    int last_r     = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offset binary: numeric value minus 256.
    function automatic int slot_value(input logic [8:0] v);
        return int'(v) - 256;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        frame_l.delete();
        frame_r.delete();
        exp_l_q.delete();
        exp_r_q.delete();
        last_l = 0;
        last_r = 0;
    endtask

    // Frame model: a frame is the list of slot values since its first slot.
    task automatic model_slot(input bit fs, input logic [8:0] l, input logic [8:0] r);
        int sl;
        int sr;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                frame_l.push_back(slot_value(l));
                frame_r.push_back(slot_value(r));
            end
        end else if (fs && frame_l.size() != 0) begin
            exp_sync++;
            frame_l.delete();
            frame_r.delete();
            frame_l.push_back(slot_value(l));
            frame_r.push_back(slot_value(r));
        end else begin
            frame_l.push_back(slot_value(l));
            frame_r.push_back(slot_value(r));
            if (frame_l.size() == SLOTS) begin
                sl = 0;
                sr = 0;
                foreach (frame_l[k]) sl += frame_l[k];
                foreach (frame_r[k]) sr += frame_r[k];
                exp_l_q.push_back(sl);
                exp_r_q.push_back(sr);
                last_l = sl;
                last_r = sr;
                frame_l.delete();
                frame_r.delete();
            end
        end
    endtask

    // Present one slot for one cycle, then idle for gap cycles with junk inputs.
    task automatic drive_slot(input bit fs, input logic [8:0] l, input logic [8:0] r,
                              input int gap);
        bus.sample_en   = 1'b1;
        bus.frame_start = fs;
        bus.MOL         = l;
        bus.MOR         = r;
        @(posedge MCLK);
        #1;
        model_slot(fs, l, r);
        bus.sample_en   = 1'b0;
        bus.frame_start = 1'($urandom_range(0, 1));
        bus.MOL         = 9'($urandom);
        bus.MOR         = 9'($urandom);
        repeat (gap) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    // Monitor: compare every published frame against the scoreboard.
    always @(negedge MCLK) begin : monitor
        int el;
        int er;
        if (!reset) begin
            if (bus.out_valid) begin
                seen_valid++;
                if (exp_l_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    el = exp_l_q.pop_front();
                    er = exp_r_q.pop_front();
                    check("out_l", int'($signed(bus.out_l)), el);
                    check("out_r", int'($signed(bus.out_r)), er);
                end
            end
            if (bus.sync_err) seen_sync++;
        end
    end

    logic [8:0] rl_a[SLOTS];
    logic [8:0] rr_a[SLOTS];

    initial begin
        int base_valid;
        int base_sync;
        int dense_l;
        int dense_r;
        bit fs;

        bus.sample_en   = 1'b0;
        bus.frame_start = 1'b0;
        bus.MOL         = 9'h100;
        bus.MOR         = 9'h100;
        repeat (3) @(posedge MCLK);
        #1;
        check("reset_out_l", int'(bus.out_l), 0);
        check("reset_out_r", int'(bus.out_r), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_sync_err", int'(bus.sync_err), 0);
        check("reset_locked", int'(bus.locked), 0);
        reset = 1'b0;
        settle(1);

        // Pre-lock rejection.
        for (int i = 0; i < 5; i++) drive_slot(1'b0, 9'($urandom), 9'($urandom), 1);
        check("prelock_locked", int'(bus.locked), 0);
        check("prelock_no_valid", seen_valid, 0);

        // Silence frame, with exact latency and pulse width.
        for (int i = 0; i < SLOTS; i++) begin
            drive_slot(i == 0, 9'h100, 9'h100, 0);
            if (i == 0) check("locked_after_fs", int'(bus.locked), 1);
        end
        @(negedge MCLK);
        check("silence_valid_latency", int'(bus.out_valid), 1);
        check("silence_out_l", int'($signed(bus.out_l)), 0);
        @(negedge MCLK);
        check("silence_valid_width", int'(bus.out_valid), 0);
        settle(1);

        // Full scale.
        for (int i = 0; i < SLOTS; i++) drive_slot(i == 0, 9'h1FF, 9'h000, $urandom_range(0, 1));
        settle(2);
        check("fullscale_out_l", int'(bus.out_l), int'(16'h17E8));
        check("fullscale_out_r", int'(bus.out_r), int'(16'hE800));

        // Resync at slot 10.
        base_valid = seen_valid;
        base_sync  = seen_sync;
        for (int i = 0; i < 10; i++) drive_slot(i == 0, 9'($urandom), 9'($urandom), 0);
        drive_slot(1'b1, 9'($urandom), 9'($urandom), 0);
        @(negedge MCLK);
        check("resync_sync_err", int'(bus.sync_err), 1);
        check("resync_no_valid", int'(bus.out_valid), 0);
        check("resync_hold_l", int'($signed(bus.out_l)), last_l);
        @(negedge MCLK);
        check("resync_pulse_width", int'(bus.sync_err), 0);
        settle(1);
        for (int i = 0; i < SLOTS - 1; i++) drive_slot(1'b0, 9'($urandom), 9'($urandom), 0);
        settle(2);
        check("resync_one_frame", seen_valid - base_valid, 1);
        check("resync_one_err", seen_sync - base_sync, 1);

        // Dense versus sparse strobes with identical data.
        for (int i = 0; i < SLOTS; i++) begin
            rl_a[i] = 9'($urandom);
            rr_a[i] = 9'($urandom);
        end
        for (int i = 0; i < SLOTS; i++) drive_slot(i == 0, rl_a[i], rr_a[i], 0);
        settle(2);
        dense_l = int'($signed(bus.out_l));
        dense_r = int'($signed(bus.out_r));
        for (int i = 0; i < SLOTS; i++) drive_slot(i == 0, rl_a[i], rr_a[i], 5);
        settle(2);
        check("sparse_eq_dense_l", int'($signed(bus.out_l)), dense_l);
        check("sparse_eq_dense_r", int'($signed(bus.out_r)), dense_r);

        // Random traffic with occasional frame_start and gaps.
        for (int i = 0; i < 400; i++) begin
            fs = ($urandom_range(0, 29) == 0);
            drive_slot(fs, 9'($urandom), 9'($urandom), $urandom_range(0, 2));
        end
        settle(3);
        check("random_sync_count", seen_sync, exp_sync);

        // Mid-frame reset at slot 12 after a known non-zero frame.
        for (int i = 0; i < SLOTS; i++) drive_slot(i == 0, 9'h1FF, 9'h000, 0);
        settle(2);
        for (int i = 0; i < 12; i++) drive_slot(i == 0, 9'($urandom), 9'($urandom), 0);
        check("pending_before_reset", exp_l_q.size(), 0);
        reset = 1'b1;
        #1;
        check("midreset_out_l", int'(bus.out_l), 0);
        check("midreset_out_r", int'(bus.out_r), 0);
        check("midreset_locked", int'(bus.locked), 0);
        check("midreset_out_valid", int'(bus.out_valid), 0);
        model_reset();
        settle(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive_slot(1'b0, 9'($urandom), 9'($urandom), 0);
        check("postreset_unlocked", int'(bus.locked), 0);
        for (int i = 0; i < SLOTS; i++) drive_slot(i == 0, 9'($urandom), 9'($urandom), 0);
        check("postreset_locked", int'(bus.locked), 1);

        settle(5);
        check("pending_frames", exp_l_q.size(), 0);
        check("final_sync_count", seen_sync, exp_sync);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
